// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- programmable integer clock divider
//
// Divides clk by a run-time divisor N. The count runs 0..N-1 and wraps. clk_out
// is high for the first ceil(N/2) counts of each period, and tick pulses on the
// first cycle of each period. A new divisor is captured into a one-deep pending
// slot. It takes effect on the next wrap, so no period is ever truncated.
//
// Optional feature (macro CLK_DIV_ODD_50_EN): for odd N the high phase is
// floor(N/2) cycles plus a half cycle. The half cycle comes from a register
// clocked on the falling edge of clk, which gives a 50 % duty cycle. Without the
// macro, odd N gives a high phase of ceil(N/2) whole cycles.
//
// Parameters
//   WIDTH        counter / divisor width in bits (>= 2)
//   DEFAULT_DIV  divisor in effect after reset (2 .. 2^WIDTH-1)
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   en           count enable; low freezes all divider state
//   div_in       requested divisor (0 and 1 are clamped to 2)
//   div_valid    div_in is valid
//   div_ready    high when the pending slot is empty
//   clk_out      divided clock, period N clk cycles
//   tick         one-cycle pulse on the first cycle of each period
//   active_div   divisor currently in effect
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 32768
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] active_div
);

    localparam logic [WIDTH-1:0] DEF_DIV    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_DIV_M1 = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] MIN_DIV    = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q,   pend_d;
    logic             pend_v_q, pend_v_d;
    logic             pos_q,    pos_d;
    logic             tick_q,   tick_d;

    logic             wrap;
    logic             accept;
    logic [WIDTH:0]   hi_lim;   // one extra bit so that N = 2^WIDTH-1 cannot overflow

    assign div_ready = ~pend_v_q;
    assign accept    = div_valid & ~pend_v_q;
    assign wrap      = (cnt_q == (active_q - WIDTH'(1)));

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        pos_d    = pos_q;
        tick_d   = 1'b0;
        hi_lim   = '0;

        if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_v_q) begin
                    active_d = pend_q;
                    pend_v_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end

            // The threshold comes from the divisor that applies to the
            // new count, so the first period after a change is shaped by the new N.
`ifdef CLK_DIV_ODD_50_EN
            // floor(N/2). For odd N, the falling-edge stage adds the last half cycle.
            hi_lim = {1'b0, active_d} >> 1;
`else
            // ceil(N/2)
            hi_lim = ({1'b0, active_d} + (WIDTH+1)'(1)) >> 1;
`endif
            pos_d = ({1'b0, cnt_d} < hi_lim);
        end

        // A divisor accepted on a wrap edge waits for the next wrap. The apply
        // above used the old pending flag, which is clear whenever accept is high.
        if (accept) begin
            pend_d   = (div_in < MIN_DIV) ? MIN_DIV : div_in;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= DEF_DIV_M1;
            active_q <= DEF_DIV;
            pend_q   <= DEF_DIV;
            pend_v_q <= 1'b0;
            pos_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            pos_q    <= pos_d;
            tick_q   <= tick_d;
        end
    end

`ifdef CLK_DIV_ODD_50_EN
    // This stage repeats pos_q half a cycle later. ORing it in adds half a cycle
    // at the end of the high phase. The OR is used only for odd divisors. At every
    // wrap pos_q is high, so switching between odd and even N cannot glitch.
    logic neg_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out = pos_q | (active_q[0] & neg_q);
`else
    assign clk_out = pos_q;
`endif

    assign tick       = tick_q;
    assign active_div = active_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning counter and divisor width in bits (minimum 2).
REQ-002 SHALL have parameter DEFAULT_DIV, default 32768, meaning divisor loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; low freezes all divider state.
REQ-006 SHALL have port div_in  input  WIDTH  requested divisor N.
REQ-007 SHALL have port div_valid  input  1  div_in is valid.
REQ-008 SHALL have port div_ready  output  1  block can accept a new divisor.
REQ-009 SHALL have port clk_out  output  1  divided clock, period N clk cycles.
REQ-010 SHALL have port tick  output  1  one-cycle pulse at each period start.
REQ-011 SHALL have port active_div  output  WIDTH  divisor currently in effect.

Function
REQ-012 SHALL keep counter cnt in 0..N-1, where N = active_div; cnt advances on each clk edge with en=1 and wraps from N-1 to 0.
REQ-013 SHALL register clk_out = 1 while cnt < H and 0 otherwise, where H = ceil(N/2) (N=2: 1 high, 1 low; N=5: 3 high, 2 low).
REQ-014 SHALL register tick = 1 for exactly the one cycle in which cnt = 0 after an enabled wrap; otherwise 0.
REQ-015 SHALL, with en=0, hold cnt, clk_out and active_div, and drive tick = 0.
REQ-016 SHALL accept a divisor on any clk edge with div_valid=1 and div_ready=1, storing it in a pending register.
REQ-017 SHALL clamp accepted div_in values 0 and 1 to 2.
REQ-018 SHALL deassert div_ready in the cycle after acceptance and keep it low while a divisor is pending.
REQ-019 SHALL move the pending divisor into active_div on the next enabled wrap edge (cnt N-1 -> 0), so the new period starts with the new N and there is no runt pulse.
REQ-020 SHALL reassert div_ready in the cycle after the pending divisor is applied.
REQ-021 SHALL apply a divisor accepted on the same edge as a wrap at the following wrap, not the current one.
REQ-022 SHALL keep the pending divisor indefinitely while en=0.
REQ-023 SHALL ignore div_in while div_ready=0; there is no overwrite of a pending divisor.

Reset
REQ-024 SHALL, while rst=1, force cnt = DEFAULT_DIV-1, active_div = DEFAULT_DIV, clk_out = 0, tick = 0, div_ready = 1 and the pending register empty.
REQ-025 SHALL make the first enabled edge after reset release wrap cnt to 0, set clk_out = 1 and pulse tick.
REQ-026 SHALL, on reset asserted mid-period or with a divisor pending, discard the pending divisor and return to the REQ-024 state.

Configuration
REQ-027 SHALL support macro CLK_DIV_ODD_50_EN.
REQ-028 SHALL, with CLK_DIV_ODD_50_EN defined and N odd, make clk_out high for exactly N/2 clk periods: the high phase is floor(N/2) cycles plus a half cycle generated from a falling-edge register (same asynchronous reset).
REQ-029 SHALL, without the macro, follow REQ-013 for odd N; even-N behaviour and tick are identical in both builds.

Verification
REQ-030 SHALL cover: DEFAULT_DIV=4, en=1 after reset -> clk_out pattern 1100 repeating, tick every 4th cycle starting on the first edge.
REQ-031 SHALL cover: load div_in=5 mid-period -> div_ready low until the next wrap; new period shows 3 high/2 low (macro off) or 2.5 high/2.5 low (macro on); active_div=5 from the wrap edge.
REQ-032 SHALL cover: div_in=0 and div_in=1 -> active_div=2, clk_out toggles every cycle.
REQ-033 SHALL cover: en=0 for 10 cycles mid-high-phase -> clk_out and cnt frozen, tick=0; after resume the period completes with no extra or missing cycles.
REQ-034 SHALL cover: div_valid on the wrap edge with N=6 -> one more 6-cycle period, then the new N.
REQ-035 SHALL cover: rst pulse while a divisor is pending -> pending divisor dropped, active_div=DEFAULT_DIV, div_ready=1, clk_out=0.
